// File: rtl/interrupt_controller_if.sv
// Handshake bundle between the interrupt front-end and the multi-cycle MIPS ControlUnit.
// master = interrupt front-end side, slave = ControlUnit side.
interface interrupt_controller_if;
    logic        nmint;
    logic        interrupt;
    logic        busy;
    logic [31:0] vector_addr;
    logic [31:0] epc;
    logic        savePC;
    logic        INA;
    logic [31:0] pcinput;
    logic        int_done;

    modport master (
        output nmint, interrupt, busy, vector_addr, epc,
        input  savePC, INA, pcinput, int_done
    );

    modport slave (
        input  nmint, interrupt, busy, vector_addr, epc,
        output savePC, INA, pcinput, int_done
    );
endinterface

// File: rtl/interrupt_controller.sv
// Interrupt front-end for the MIPS ControlUnit: synchronises IRQ/NMI lines, masks, prioritises,
// captures EPC and supplies the handler vector. Define INTC_LEVEL_MODE_EN for level-sensitive IRQs.
module interrupt_controller #(
    parameter int          NUM_IRQ    = 4,
    parameter logic [31:0] MI_BASE    = 32'h0000_0040,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010,
    parameter logic [31:0] NMI_VECTOR = 32'h0000_0080,
    parameter int          ID_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_IRQ-1:0]   irq_in,
    input  logic                 nmi_in,
    input  logic                 mask_wr,
    input  logic [NUM_IRQ-1:0]   mask_wdata,
    interrupt_controller_if.master cu,
    output logic [ID_W-1:0]      irq_id,
    output logic [NUM_IRQ-1:0]   irq_mask,
    output logic                 in_service
);

    typedef enum logic [1:0] {IDLE, SVC_MI, SVC_NMI} state_t;

    function automatic logic [31:0] mi_vector(input logic [ID_W-1:0] s);
        return MI_BASE + (32'(s) * VEC_STRIDE);
    endfunction

    state_t               state_q, state_d;
    logic [NUM_IRQ-1:0]   irq_sync_p0, irq_sync_p1;
    logic                 nmi_sync_p0, nmi_sync_p1, nmi_sync_p2;
    logic [2:0]           prime_q;
    logic                 primed;
    logic [NUM_IRQ-1:0]   pending_q, pending_d;
    logic                 nmi_pending_q, nmi_pending_d;
    logic [NUM_IRQ-1:0]   irq_mask_q;
    logic [NUM_IRQ-1:0]   req;
    logic [ID_W-1:0]      sel;
    logic [31:0]          epc_q;
    logic [31:0]          vector_q;
    logic [ID_W-1:0]      irq_id_q;
    logic                 in_service_q;
    logic                 take_mi, take_nmi, leave;
    logic                 nmi_rise;

    // Lines held high through reset are not edges: detection waits until the whole chain
    // has sampled the post-reset input.
    assign primed = prime_q[2];

    // Stage p0/p1: two-flop synchronisers; p2 holds the previous synchronised value for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_sync_p0 <= '0;
            irq_sync_p1 <= '0;
            nmi_sync_p0 <= 1'b0;
            nmi_sync_p1 <= 1'b0;
            nmi_sync_p2 <= 1'b0;
            prime_q     <= '0;
        end else begin
            irq_sync_p0 <= irq_in;
            irq_sync_p1 <= irq_sync_p0;
            nmi_sync_p0 <= nmi_in;
            nmi_sync_p1 <= nmi_sync_p0;
            nmi_sync_p2 <= nmi_sync_p1;
            prime_q     <= {prime_q[1:0], 1'b1};
        end
    end

    assign nmi_rise = nmi_sync_p1 & ~nmi_sync_p2 & primed;

`ifdef INTC_LEVEL_MODE_EN
    always_comb begin
        pending_d = irq_sync_p1;
    end
`else
    logic [NUM_IRQ-1:0] irq_sync_p2;
    logic [NUM_IRQ-1:0] irq_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_sync_p2 <= '0;
        else        irq_sync_p2 <= irq_sync_p1;
    end

    assign irq_rise = irq_sync_p1 & ~irq_sync_p2 & {NUM_IRQ{primed}};

    // Acknowledge clears first so a same-cycle new edge keeps the bit set.
    always_comb begin
        pending_d = pending_q;
        if (take_mi) pending_d[sel] = 1'b0;
        pending_d = pending_d | irq_rise;
    end
`endif

    assign req = pending_q & irq_mask_q;

    always_comb begin
        sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) sel = ID_W'(i);
        end
    end

    always_comb begin
        nmi_pending_d = nmi_pending_q;
        if (take_nmi) nmi_pending_d = 1'b0;
        if (nmi_rise) nmi_pending_d = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        take_mi  = 1'b0;
        take_nmi = 1'b0;
        leave    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cu.savePC) begin
                    if (cu.INA) begin
                        take_mi = 1'b1;
                        state_d = SVC_MI;
                    end else begin
                        take_nmi = 1'b1;
                        state_d  = SVC_NMI;
                    end
                end
            end
            SVC_MI, SVC_NMI: begin
                if (cu.int_done && !cu.savePC) begin
                    leave   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Stage p3: architectural state and registered vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q     <= '0;
            nmi_pending_q <= 1'b0;
            irq_mask_q    <= '0;
            epc_q         <= '0;
            irq_id_q      <= '0;
            in_service_q  <= 1'b0;
            vector_q      <= NMI_VECTOR;
        end else begin
            pending_q     <= pending_d;
            nmi_pending_q <= nmi_pending_d;
            if (mask_wr) irq_mask_q <= mask_wdata;
            if (take_mi || take_nmi) begin
                epc_q        <= cu.pcinput;
                in_service_q <= 1'b1;
            end else if (leave) begin
                in_service_q <= 1'b0;
            end
            if (take_mi) irq_id_q <= sel;
            vector_q <= nmi_pending_q ? NMI_VECTOR : mi_vector(sel);
        end
    end

    assign cu.interrupt   = (|req) & ~in_service_q;
    assign cu.nmint       = nmi_pending_q & ~in_service_q;
    assign cu.busy        = in_service_q | (state_q != IDLE);
    assign cu.vector_addr = vector_q;
    assign cu.epc         = epc_q;
    assign irq_id         = irq_id_q;
    assign irq_mask       = irq_mask_q;
    assign in_service     = in_service_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed-vector bench for interrupt_controller (default edge-triggered build).
module tb_interrupt_controller;
    logic       clk;
    logic       rst_n;
    logic [3:0] irq_in;
    logic       nmi_in;
    logic       mask_wr;
    logic [3:0] mask_wdata;
    logic [1:0] irq_id;
    logic [3:0] irq_mask;
    logic       in_service;
    int         n_vec;
    int         n_miss;

    interrupt_controller_if cu_if();

    interrupt_controller dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .nmi_in(nmi_in),
        .mask_wr(mask_wr), .mask_wdata(mask_wdata), .cu(cu_if),
        .irq_id(irq_id), .irq_mask(irq_mask), .in_service(in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mask(input logic [3:0] m);
        mask_wdata = m;
        mask_wr    = 1'b1;
        tick();
        mask_wr    = 1'b0;
    endtask

    task automatic ack(input logic ina, input logic [31:0] pc);
        cu_if.INA     = ina;
        cu_if.pcinput = pc;
        cu_if.savePC  = 1'b1;
        tick();
        cu_if.savePC  = 1'b0;
    endtask

    task automatic done();
        cu_if.int_done = 1'b1;
        tick();
        cu_if.int_done = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_miss = 0;
        rst_n = 1'b0; irq_in = '0; nmi_in = 1'b0; mask_wr = 1'b0; mask_wdata = '0;
        cu_if.savePC = 1'b0; cu_if.INA = 1'b0; cu_if.pcinput = '0; cu_if.int_done = 1'b0;
        tick(); tick();
        chk("rst_vec", cu_if.vector_addr, 32'h80);
        chk("rst_int", 32'(cu_if.interrupt), 32'd0);
        chk("rst_busy", 32'(cu_if.busy), 32'd0);
        rst_n = 1'b1;
        repeat (4) tick();

        // single IRQ
        write_mask(4'hF);
        chk("mask_f", 32'(irq_mask), 32'hF);
        irq_in = 4'b0100;
        tick(); tick();
        chk("lat2_int", 32'(cu_if.interrupt), 32'd0);
        tick();
        chk("lat3_int", 32'(cu_if.interrupt), 32'd1);
        tick();
        chk("vec_irq2", cu_if.vector_addr, 32'h60);
        ack(1'b1, 32'h124);
        chk("epc_124", cu_if.epc, 32'h124);
        chk("id_2", 32'(irq_id), 32'd2);
        chk("busy_svc", 32'(cu_if.busy), 32'd1);
        chk("int_svc", 32'(cu_if.interrupt), 32'd0);
        irq_in = '0;
        done();
        chk("insvc_done", 32'(in_service), 32'd0);
        chk("int_cleared", 32'(cu_if.interrupt), 32'd0);
        chk("epc_hold", cu_if.epc, 32'h124);

        // priority and mask
        write_mask(4'b1000);
        irq_in = 4'b1010;
        repeat (4) tick();
        chk("vec_masked", cu_if.vector_addr, 32'h70);
        chk("int_masked", 32'(cu_if.interrupt), 32'd1);
        write_mask(4'hF);
        chk("vec_premask", cu_if.vector_addr, 32'h70);
        tick();
        chk("vec_unmask", cu_if.vector_addr, 32'h50);
        ack(1'b1, 32'h130);
        chk("id_1", 32'(irq_id), 32'd1);
        done();
        chk("int_irq3", 32'(cu_if.interrupt), 32'd1);
        ack(1'b1, 32'h134);
        chk("id_3", 32'(irq_id), 32'd3);
        irq_in = '0;
        done();
        chk("int_none", 32'(cu_if.interrupt), 32'd0);

        // NMI precedence
        nmi_in = 1'b1; irq_in = 4'b0001;
        repeat (4) tick();
        chk("nmi_req", 32'(cu_if.nmint), 32'd1);
        chk("nmi_int", 32'(cu_if.interrupt), 32'd1);
        chk("vec_nmi", cu_if.vector_addr, 32'h80);
        ack(1'b0, 32'h200);
        chk("nmi_insvc", 32'(in_service), 32'd1);
        chk("nmi_masked", 32'(cu_if.nmint), 32'd0);
        chk("epc_200", cu_if.epc, 32'h200);
        nmi_in = 1'b0; irq_in = '0;
        done();
        chk("int_after_nmi", 32'(cu_if.interrupt), 32'd1);
        chk("nmi_cleared", 32'(cu_if.nmint), 32'd0);
        tick();
        chk("vec_irq0", cu_if.vector_addr, 32'h40);

        // no nesting
        ack(1'b1, 32'h300);
        chk("id_0", 32'(irq_id), 32'd0);
        nmi_in = 1'b1;
        repeat (4) tick();
        chk("nest_nmint", 32'(cu_if.nmint), 32'd0);
        chk("nest_busy", 32'(cu_if.busy), 32'd1);
        done();
        chk("nmi_after_ret", 32'(cu_if.nmint), 32'd1);
        ack(1'b0, 32'h310);
        nmi_in = 1'b0;
        done();
        chk("nmi_gone", 32'(cu_if.nmint), 32'd0);

        // simultaneous set and clear on irq 0
        irq_in = 4'b0001;
        repeat (4) tick();
        chk("p0_set", 32'(cu_if.interrupt), 32'd1);
        irq_in = '0;
        repeat (3) tick();
        irq_in = 4'b0001;
        tick(); tick();
        ack(1'b1, 32'h400);
        chk("sc_id", 32'(irq_id), 32'd0);
        chk("sc_int_svc", 32'(cu_if.interrupt), 32'd0);
        done();
        chk("sc_kept", 32'(cu_if.interrupt), 32'd1);
        ack(1'b1, 32'h404);
        done();
        chk("sc_drained", 32'(cu_if.interrupt), 32'd0);

        // asynchronous reset mid-service
        irq_in = '0;
        repeat (3) tick();
        irq_in = 4'b0010;
        repeat (4) tick();
        ack(1'b1, 32'h500);
        chk("pre_rst_svc", 32'(in_service), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_insvc", 32'(in_service), 32'd0);
        chk("arst_busy", 32'(cu_if.busy), 32'd0);
        chk("arst_epc", cu_if.epc, 32'h0);
        chk("arst_id", 32'(irq_id), 32'd0);
        chk("arst_mask", 32'(irq_mask), 32'd0);
        chk("arst_vec", cu_if.vector_addr, 32'h80);
        chk("arst_nmint", 32'(cu_if.nmint), 32'd0);
        chk("arst_int", 32'(cu_if.interrupt), 32'd0);
        #2 rst_n = 1'b1;
        write_mask(4'hF);
        repeat (6) tick();
        chk("held_no_edge", 32'(cu_if.interrupt), 32'd0);
        irq_in = '0;
        repeat (3) tick();
        irq_in = 4'b0010;
        repeat (3) tick();
        chk("new_edge_int", 32'(cu_if.interrupt), 32'd1);
        tick();
        chk("new_edge_vec", cu_if.vector_addr, 32'h50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
Upstream interrupt front-end for the multi-cycle MIPS ControlUnit. It synchronises and latches device IRQ lines and an NMI line, applies a mask, and picks the highest-priority request. It drives the ControlUnit's nmint/interrupt/busy inputs and consumes its savePC/INA outputs. It captures the return PC (epc) and supplies the handler vector used when PCSrc=3.

Parameters:
NUM_IRQ, 4, number of maskable IRQ lines; index 0 has the highest priority.
MI_BASE, 32'h0000_0040, vector address of maskable IRQ 0.
VEC_STRIDE, 32'h0000_0010, byte spacing between maskable vectors.
NMI_VECTOR, 32'h0000_0080, vector address of the NMI handler.

Ports:
clk  in  1  system clock; rising edge.
rst_n  in  1  asynchronous, active-low reset.
irq_in  in  NUM_IRQ  asynchronous device interrupt lines, active-high.
nmi_in  in  1  asynchronous non-maskable interrupt line, active-high.
mask_wr  in  1  one-cycle strobe; load irq_mask from mask_wdata.
mask_wdata  in  NUM_IRQ  new mask; 1 = enabled.
savePC  in  1  from ControlUnit; interrupt entry taken this cycle.
INA  in  1  from ControlUnit; qualifies savePC (1 = maskable, 0 = NMI).
pcinput  in  32  current PC from the datapath.
int_done  in  1  one-cycle pulse; handler has returned.
nmint  out  1  to ControlUnit; NMI request.
interrupt  out  1  to ControlUnit; maskable request.
busy  out  1  to ControlUnit; blocks maskable entry.
vector_addr  out  32  handler address for PCSrc=3.
epc  out  32  saved return PC.
irq_id  out  clog2(NUM_IRQ)  ID of the IRQ in service.
irq_mask  out  NUM_IRQ  current mask.
in_service  out  1  a handler is active.

Behaviour:
- Reset (rst_n=0, asynchronous): all of the following clear to 0: pending bits, nmi_pending, synchroniser flops, irq_mask, epc, irq_id, nmint, interrupt, busy, in_service. vector_addr resets to NMI_VECTOR. State = IDLE.
- Synchronisation: irq_in and nmi_in each pass through 2 flops. A rising edge on a synchronised line sets its pending bit. Latency from input edge to nmint/interrupt high is 3 clk.
- Selection (combinational from registers): sel = lowest index i with pending[i] & irq_mask[i].
- interrupt = |(pending & irq_mask) and not in_service.
- nmint = nmi_pending and not in_service.
- busy = in_service, or any state other than IDLE.
- vector_addr (registered, updated every cycle):
  - NMI_VECTOR if nmi_pending.
  - else MI_BASE + sel*VEC_STRIDE.
  - Width 32, wraps modulo 2^32.
- FSM states: IDLE, SVC_MI, SVC_NMI.
  - IDLE -> SVC_NMI on savePC & ~INA: epc<=pcinput; nmi_pending<=0; in_service<=1.
  - IDLE -> SVC_MI on savePC & INA: epc<=pcinput; irq_id<=sel; pending[sel]<=0; in_service<=1.
  - SVC_MI / SVC_NMI -> IDLE on int_done: in_service<=0. epc and irq_id hold their values.
  - No nesting. Edges arriving during service stay pending and are presented after return.
  - savePC while already in service is ignored.
- Simultaneous events:
  - Pending clear and a new edge on the same bit in the same cycle: set wins.
  - mask_wr and savePC in the same cycle: selection uses the pre-write mask.
  - savePC and int_done in the same cycle: int_done is ignored.
  - NMI and maskable both pending: nmint asserted and vector_addr = NMI_VECTOR. The ControlUnit's priority (INA=0) decides entry.
- Masked pending bits are retained and assert interrupt once unmasked.
- An rst_n assertion mid-service aborts the service; all state clears immediately.

Optional Feature:
INTC_LEVEL_MODE_EN
- Defined: maskable lines are level-sensitive. pending[i] = synchronised irq_in[i] each cycle. Acknowledge does not clear pending; the device must deassert its line. NMI stays edge-triggered.
- Undefined: edge-triggered latching as described above.

Test Plan:
- Reset: rst_n low mid-cycle with irq_in=4'b0010 -> all outputs 0 and vector_addr=32'h80 immediately. After release, interrupt stays 0 until a new edge.
- Single IRQ: mask=4'b1111, rising edge on irq_in[2] -> interrupt=1 after 3 clk and vector_addr=32'h60. savePC=1, INA=1, pcinput=32'h124 -> epc=32'h124, irq_id=2, busy=1, interrupt=0.
- Priority and mask: edges on irq_in[1] and irq_in[3] with mask=4'b1000 -> vector_addr=32'h70. Write mask=4'b1111 -> vector_addr=32'h50 next cycle.
- NMI precedence: nmi edge plus irq_in[0] edge -> nmint=1, interrupt=1, vector_addr=32'h80. savePC with INA=0 -> nmi_pending clears, pending[0] stays. int_done -> interrupt=1, vector_addr=32'h40.
- No nesting: during SVC_MI, edge on nmi_in -> nmint stays 0. After int_done, nmint=1 within 1 clk.
- Simultaneous set/clear: ack of irq 0 in the same cycle as a new irq_in[0] edge -> pending[0] remains 1.
